// File: rtl/fetch_tile_scheduler.sv
// fetch_tile_scheduler: round-robin owner of the shared fetch read path.
// Per grant it pulses an address reset, then one fetch per tile.
module fetch_tile_scheduler #(
   parameter int NUM_REQ        = 3,
   parameter int TILE_W         = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*TILE_W-1:0] req_tiles,
   input  logic                      abort,
   input  logic                      clear_err,
   input  logic                      fetch_done,
   output logic                      start_fetch,
   output logic                      reset_addr_counter,
   output logic [1:0]                buffer_select,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        req_done,
   output logic                      busy,
   output logic                      timeout_err,
   output logic [1:0]                err_id
);
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST_ADDR,
      S_START,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        rr_q, rr_d;
   logic [1:0]        g_q, g_d;
   logic [TILE_W-1:0] rem_q, rem_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              err_q, err_d;
   logic [1:0]        err_id_q, err_id_d;

   logic              pick_vld;
   logic [1:0]        pick_idx;
   logic [TILE_W-1:0] pick_tiles;
   logic [1:0]        nxt_rr;
   logic              tmo_hit;

   // Scan downward so the smallest offset from rr_q wins.
   always_comb begin
      int j;
      j        = 0;
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         j = int'(rr_q) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (req[j]) begin
            pick_vld = 1'b1;
            pick_idx = 2'(j);
         end
      end
   end

   assign pick_tiles = req_tiles[pick_idx*TILE_W +: TILE_W];
   assign nxt_rr = (int'(g_q) >= NUM_REQ - 1) ? 2'd0 : g_q + 2'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rr_q     <= '0;
         g_q      <= '0;
         rem_q    <= '0;
         tmo_q    <= '0;
         err_q    <= 1'b0;
         err_id_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         g_q      <= g_d;
         rem_q    <= rem_d;
         tmo_q    <= tmo_d;
         err_q    <= err_d;
         err_id_q <= err_id_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      g_d      = g_q;
      rem_d    = rem_q;
      tmo_d    = tmo_q;
      err_d    = err_q;
      err_id_d = err_id_q;
      tmo_hit  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               g_d     = pick_idx;
               rem_d   = pick_tiles;
               state_d = (pick_tiles == '0) ? S_DONE : S_RST_ADDR;
            end
         end
         S_RST_ADDR: state_d = S_START;
         S_START: begin
            tmo_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (fetch_done) begin
               if (rem_q != '0) rem_d = rem_q - 1'b1;
               state_d = (rem_q <= TILE_W'(1)) ? S_DONE : S_START;
            end else begin
               tmo_d = tmo_q + 1'b1;
               if (tmo_d == TMO_LAST) begin
                  tmo_hit = 1'b1;
                  state_d = S_IDLE;
                  rr_d    = nxt_rr;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            rr_d    = nxt_rr;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         rr_d    = nxt_rr;
         tmo_hit = 1'b0;
      end
      if (tmo_hit) begin
         err_d    = 1'b1;
         err_id_d = g_q;
      end
      if (clear_err) begin
         err_d    = 1'b0;
         err_id_d = '0;
      end
   end

   always_comb begin
      start_fetch        = (state_q == S_START);
      reset_addr_counter = (state_q == S_RST_ADDR);
      busy               = (state_q != S_IDLE);
      grant              = '0;
      buffer_select      = '0;
      req_done           = '0;
      if (busy) begin
         grant[g_q]    = 1'b1;
         buffer_select = g_q;
      end
      if (state_q == S_DONE && !abort) req_done[g_q] = 1'b1;
   end

   assign timeout_err = err_q;
   assign err_id      = err_id_q;

endmodule

// File: tb/tb_fetch_tile_scheduler.sv
// tb_fetch_tile_scheduler: directed vectors with an event scoreboard
// for fetch_tile_scheduler.
module tb_fetch_tile_scheduler;
   localparam int NUM_REQ = 3;
   localparam int TILE_W  = 8;
   localparam int TMO     = 1024;

   localparam logic [1:0] K_RST  = 2'd0;
   localparam logic [1:0] K_SF   = 2'd1;
   localparam logic [1:0] K_DONE = 2'd2;
   localparam logic [1:0] K_TMO  = 2'd3;

   logic                      clk;
   logic                      rst;
   logic [NUM_REQ-1:0]        req;
   logic [TILE_W-1:0]         tiles [NUM_REQ];
   logic [NUM_REQ*TILE_W-1:0] req_tiles;
   logic                      abort;
   logic                      clear_err;
   logic                      fd_man;
   logic                      fd_auto;
   logic                      fetch_done;
   logic                      start_fetch;
   logic                      reset_addr_counter;
   logic [1:0]                buffer_select;
   logic [NUM_REQ-1:0]        grant;
   logic [NUM_REQ-1:0]        req_done;
   logic                      busy;
   logic                      timeout_err;
   logic [1:0]                err_id;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int auto_lat = 0;
   int fd_cnt = 0;
   logic [7:0] exp_q [$];

   assign req_tiles  = {tiles[2], tiles[1], tiles[0]};
   assign fetch_done = fd_man | fd_auto;

   fetch_tile_scheduler #(
      .NUM_REQ(NUM_REQ),
      .TILE_W(TILE_W),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .req_tiles(req_tiles),
      .abort(abort),
      .clear_err(clear_err),
      .fetch_done(fetch_done),
      .start_fetch(start_fetch),
      .reset_addr_counter(reset_addr_counter),
      .buffer_select(buffer_select),
      .grant(grant),
      .req_done(req_done),
      .busy(busy),
      .timeout_err(timeout_err),
      .err_id(err_id)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] ev(input logic [1:0] k,
                                     input logic [2:0] g,
                                     input logic [1:0] b);
      return {1'b0, k, g, b};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   task automatic sb_check(input logic [7:0] got);
      logic [7:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL sb_unexpected: got %h expected none", got);
      end else begin
         e = exp_q.pop_front();
         if (got !== e) begin
            n_err++;
            $display("FAIL sb_event: got %h expected %h", got, e);
         end
      end
   endtask

   task automatic expect_grant(input int g, input int nt);
      logic [2:0] oh;
      oh = 3'b001 << g;
      exp_q.push_back(ev(K_RST, oh, 2'(g)));
      for (int i = 0; i < nt; i++) exp_q.push_back(ev(K_SF, oh, 2'(g)));
      exp_q.push_back(ev(K_DONE, oh, 2'(g)));
   endtask

   // Monitor: every output pulse is matched against the queue.
   initial begin
      logic prev_err;
      prev_err = 1'b0;
      forever begin
         @(negedge clk);
         if (reset_addr_counter) sb_check(ev(K_RST, grant, buffer_select));
         if (start_fetch) sb_check(ev(K_SF, grant, buffer_select));
         if (req_done != '0) sb_check(ev(K_DONE, req_done, buffer_select));
         if (timeout_err && !prev_err) sb_check(ev(K_TMO, 3'b000, err_id));
         prev_err = timeout_err;
      end
   end

   // Fetch-logic model: pulses fetch_done auto_lat cycles after a start.
   initial begin
      fd_auto = 1'b0;
      forever begin
         @(negedge clk);
         fd_auto = 1'b0;
         if (fd_cnt > 0) begin
            fd_cnt--;
            if (fd_cnt == 0) fd_auto = 1'b1;
         end
         if (start_fetch && auto_lat > 0) fd_cnt = auto_lat;
      end
   end

   task automatic do_reset();
      rst       = 1'b1;
      req       = '0;
      abort     = 1'b0;
      clear_err = 1'b0;
      fd_man    = 1'b0;
      auto_lat  = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_start(input string name, input int budget,
                             output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (start_fetch) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) fail(name);
   endtask

   task automatic run_until(input string name, input int n, input int budget,
                            output int t_done);
      int seen;
      seen   = 0;
      t_done = -1;
      for (int i = 0; i < budget && seen < n; i++) begin
         @(negedge clk);
         if (req_done != '0) begin
            seen++;
            t_done = cyc;
            if (seen == n) req = '0;
         end
      end
      if (seen < n) begin
         req = '0;
         fail(name);
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int ok;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1;
            break;
         end
      end
      if (ok == 0) fail(name);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_grant"}, int'(grant), 0);
      chk({tag, "_bsel"}, int'(buffer_select), 0);
      chk({tag, "_sf"}, int'(start_fetch), 0);
      chk({tag, "_rac"}, int'(reset_addr_counter), 0);
      chk({tag, "_rdone"}, int'(req_done), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, ts;
      rst       = 1'b1;
      req       = '0;
      abort     = 1'b0;
      clear_err = 1'b0;
      fd_man    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) tiles[i] = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk_quiet("rst");
      chk("rst_terr", int'(timeout_err), 0);
      chk("rst_errid", int'(err_id), 0);

      // T1: two tiles, fetch_done 34 cycles after each start
      do_reset();
      tiles[0] = 8'd2;
      auto_lat = 34;
      expect_grant(0, 2);
      req = 3'b001;
      @(negedge clk);
      chk("t1_rac_lat", int'(reset_addr_counter), 1);
      @(negedge clk);
      chk("t1_sf_lat", int'(start_fetch), 1);
      run_until("t1_done", 1, 200, t1);
      wait_idle("t1_idle", 5);

      // T2: all three requesting, round-robin order 0,1,2,0
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) tiles[i] = 8'd1;
      auto_lat = 3;
      expect_grant(0, 1);
      expect_grant(1, 1);
      expect_grant(2, 1);
      expect_grant(0, 1);
      req = 3'b111;
      run_until("t2_done", 4, 200, t1);
      wait_idle("t2_idle", 5);

      // T3: zero tiles goes straight to completion
      do_reset();
      tiles[1] = 8'd0;
      exp_q.push_back(ev(K_DONE, 3'b010, 2'd1));
      t0  = cyc;
      req = 3'b010;
      run_until("t3_done", 1, 10, t1);
      chk("t3_lat_ok", int'((t1 - t0) >= 1 && (t1 - t0) <= 2), 1);
      wait_idle("t3_idle", 5);

      // T4: fetch_done withheld until timeout
      do_reset();
      tiles[2] = 8'd1;
      exp_q.push_back(ev(K_RST, 3'b100, 2'd2));
      exp_q.push_back(ev(K_SF, 3'b100, 2'd2));
      exp_q.push_back(ev(K_TMO, 3'b000, 2'd2));
      req = 3'b100;
      wait_start("t4_start", 10, ts);
      t1 = -1;
      for (int i = 0; i < TMO + 20; i++) begin
         @(negedge clk);
         if (timeout_err) begin
            t1 = cyc;
            break;
         end
      end
      req = '0;
      if (t1 < 0) fail("t4_timeout");
      chk("t4_tmo_cycles", t1 - ts, TMO);
      chk("t4_errid", int'(err_id), 2);
      chk("t4_busy", int'(busy), 0);
      @(negedge clk);
      chk("t4_busy_next", int'(busy), 0);
      repeat (3) @(negedge clk);
      chk("t4_sticky", int'(timeout_err), 1);
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      chk("t4_cleared", int'(timeout_err), 0);
      chk("t4_errid_clr", int'(err_id), 0);

      // T5: abort wins over a simultaneous fetch_done
      do_reset();
      tiles[0] = 8'd1;
      tiles[1] = 8'd1;
      exp_q.push_back(ev(K_RST, 3'b001, 2'd0));
      exp_q.push_back(ev(K_SF, 3'b001, 2'd0));
      expect_grant(1, 1);
      req = 3'b011;
      wait_start("t5_start", 10, ts);
      @(negedge clk);
      fd_man = 1'b1;
      abort  = 1'b1;
      @(negedge clk);
      fd_man   = 1'b0;
      abort    = 1'b0;
      auto_lat = 3;
      chk("t5_busy", int'(busy), 0);
      chk("t5_grant", int'(grant), 0);
      @(negedge clk);
      chk("t5_regrant", int'(grant), 2);
      req = 3'b010;
      run_until("t5_done", 1, 50, t1);
      wait_idle("t5_idle", 5);

      // T6: stray fetch_done in IDLE, then reset mid-wait
      do_reset();
      repeat (3) begin
         @(negedge clk);
         fd_man = 1'b1;
         @(negedge clk);
         fd_man = 1'b0;
         chk("t6_idle_busy", int'(busy), 0);
      end
      tiles[0] = 8'd3;
      exp_q.push_back(ev(K_RST, 3'b001, 2'd0));
      exp_q.push_back(ev(K_SF, 3'b001, 2'd0));
      req = 3'b001;
      wait_start("t6_start", 10, ts);
      repeat (3) @(negedge clk);
      chk("t6_busy_pre", int'(busy), 1);
      #2 rst = 1'b1;
      #1 chk_quiet("t6_rst");
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("t6_after_busy", int'(busy), 0);

      repeat (5) @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
